// File: rtl/fft_corr_frame_builder.sv
// Builds one lane-paired, zero-padded NFFT-point frame per run from two sample streams; 1-cycle input-to-output latency.
// Both inputs handshake together or not at all; a one-entry output register stalls both inputs while frame_tready is low.
module fft_corr_frame_builder #(
  parameter int NFFT   = 256,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 13
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [LEN_W-1:0]      N1,
  input  logic [LEN_W-1:0]      N2,
  input  logic [7:0]            n_frames,
  input  logic                  start,
  input  logic                  abort,
  output logic                  idle,
  output logic                  cfg_err,
  output logic [7:0]            frames_done,
  input  logic [DATA_W-1:0]     func_1_tdata,
  input  logic                  func_1_tvalid,
  output logic                  func_1_tready,
  input  logic [DATA_W-1:0]     func_2_tdata,
  input  logic                  func_2_tvalid,
  output logic                  func_2_tready,
  output logic [2*DATA_W-1:0]   frame_tdata,
  output logic                  frame_tvalid,
  output logic                  frame_tlast,
  input  logic                  frame_tready
);
  localparam int K_W = $clog2(NFFT);
  localparam logic [LEN_W:0] NFFT_L = (LEN_W+1)'(NFFT);
  localparam logic [K_W-1:0] K_LAST = K_W'(NFFT - 1);

  typedef enum logic {S_IDLE, S_RUN} state_t;
  state_t r_state, w_state_nxt;

  logic [K_W-1:0]      r_k;
  logic [LEN_W-1:0]    r_n1, r_n2;
  logic [7:0]          r_nfr, r_frames_done;
  logic                r_abort, r_cfg_err, r_tvalid, r_tlast;
  logic [2*DATA_W-1:0] r_tdata;

  logic [LEN_W:0]      w_sum;
  logic [LEN_W-1:0]    w_k_ext;
  logic [7:0]          w_fd_inc;
  logic w_cfg_ok, w_start_ok, w_start_bad, w_need1, w_need2;
  logic w_run, w_adv, w_last_hs, w_end, w_go, w_take;

  assign w_sum       = {1'b0, N1} + {1'b0, N2};
  assign w_cfg_ok    = (N1 != '0) && (N2 != '0) && ((w_sum - 1'b1) <= NFFT_L);
  assign w_start_ok  = (r_state == S_IDLE) && start && w_cfg_ok;
  assign w_start_bad = (r_state == S_IDLE) && start && !w_cfg_ok;

  assign w_run     = (r_state == S_RUN);
  assign w_k_ext   = LEN_W'(r_k);
  assign w_need1   = w_k_ext < r_n1;
  assign w_need2   = w_k_ext < r_n2;
  assign w_adv     = w_run && (!r_tvalid || frame_tready);
  assign w_last_hs = r_tvalid && r_tlast && frame_tready;
  assign w_fd_inc  = r_frames_done + 8'd1;
  assign w_end     = w_last_hs && (((r_nfr != 8'd0) && (w_fd_inc == r_nfr)) || r_abort || abort);
  // At the run's final handshake k has already wrapped to 0; block the next frame from starting.
  assign w_go      = w_adv && !w_end;
  assign w_take    = w_go && (!w_need1 || func_1_tvalid) && (!w_need2 || func_2_tvalid);

  always_ff @(posedge aclk) begin
    if (areset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start_ok) w_state_nxt = S_RUN;
      S_RUN:   if (w_end)      w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    idle          = (r_state == S_IDLE);
    func_1_tready = w_go && w_need1 && (!w_need2 || func_2_tvalid);
    func_2_tready = w_go && w_need2 && (!w_need1 || func_1_tvalid);
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_k           <= '0;
      r_n1          <= '0;
      r_n2          <= '0;
      r_nfr         <= '0;
      r_frames_done <= '0;
      r_abort       <= 1'b0;
      r_cfg_err     <= 1'b0;
      r_tvalid      <= 1'b0;
      r_tlast       <= 1'b0;
      r_tdata       <= '0;
    end else begin
      r_cfg_err <= w_start_bad;
      if (w_start_ok) begin
        r_n1          <= N1;
        r_n2          <= N2;
        r_nfr         <= n_frames;
        r_frames_done <= '0;
        r_k           <= '0;
        r_abort       <= 1'b0;
      end else if (w_run) begin
        r_abort <= w_end ? 1'b0 : (r_abort || abort);
        if (w_last_hs) r_frames_done <= w_fd_inc;
        if (w_take)    r_k <= r_k + 1'b1;
      end
      if (w_take) begin
        r_tdata  <= {(w_need2 ? func_2_tdata : {DATA_W{1'b0}}),
                     (w_need1 ? func_1_tdata : {DATA_W{1'b0}})};
        r_tlast  <= (r_k == K_LAST);
        r_tvalid <= 1'b1;
      end else if (w_adv) begin
        r_tvalid <= 1'b0;
        r_tlast  <= 1'b0;
      end
    end
  end

  assign cfg_err      = r_cfg_err;
  assign frames_done  = r_frames_done;
  assign frame_tdata  = r_tdata;
  assign frame_tvalid = r_tvalid;
  assign frame_tlast  = r_tlast;
endmodule

// File: tb/tb_fft_corr_frame_builder.sv
// Scoreboard bench for fft_corr_frame_builder at NFFT=8: sources and sink driven from one engine loop.
module tb_fft_corr_frame_builder;
  localparam int NFFT = 8;
  localparam int DW   = 32;
  localparam int LW   = 13;

  logic          aclk = 1'b0;
  logic          areset = 1'b1;
  logic [LW-1:0] N1 = '0, N2 = '0;
  logic [7:0]    n_frames = '0;
  logic          start = 1'b0, abort = 1'b0;
  logic          idle, cfg_err;
  logic [7:0]    frames_done;
  logic [DW-1:0] func_1_tdata = '0, func_2_tdata = '0;
  logic          func_1_tvalid = 1'b0, func_2_tvalid = 1'b0;
  logic          func_1_tready, func_2_tready;
  logic [2*DW-1:0] frame_tdata;
  logic          frame_tvalid, frame_tlast;
  logic          frame_tready = 1'b1;

  fft_corr_frame_builder #(.NFFT(NFFT), .DATA_W(DW), .LEN_W(LW)) dut (
    .aclk(aclk), .areset(areset), .N1(N1), .N2(N2), .n_frames(n_frames),
    .start(start), .abort(abort), .idle(idle), .cfg_err(cfg_err),
    .frames_done(frames_done),
    .func_1_tdata(func_1_tdata), .func_1_tvalid(func_1_tvalid), .func_1_tready(func_1_tready),
    .func_2_tdata(func_2_tdata), .func_2_tvalid(func_2_tvalid), .func_2_tready(func_2_tready),
    .frame_tdata(frame_tdata), .frame_tvalid(frame_tvalid), .frame_tlast(frame_tlast),
    .frame_tready(frame_tready)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [63:0] dat;
    logic        last;
    logic        fin;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] src1[$], src2[$];
  int n_vec = 0, n_err = 0;
  int beats = 0, gaps = 0, f2_hold = 0;
  bit mon_en = 0, rdy_alt = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  initial begin : engine
    bit hs1, hs2, ohs, prev_stall, idle_chk, idle_exp;
    logic [63:0] held;
    exp_t e;
    prev_stall = 0; idle_chk = 0; idle_exp = 0; held = '0;
    forever begin
      @(negedge aclk);
      hs1 = func_1_tvalid && func_1_tready;
      hs2 = func_2_tvalid && func_2_tready;
      ohs = frame_tvalid && frame_tready;
      if (mon_en) begin
        if (idle_chk) begin
          check("idle_after_last", idle, idle_exp);
          idle_chk = 0;
        end
        if (prev_stall) begin
          check("stall_valid", frame_tvalid, 1);
          check("stall_hold", frame_tdata, held);
        end
        if (src2.size() > 0 && !func_2_tvalid) check("f1_alone", func_1_tready, 0);
        if (ohs) begin
          if (exp_q.size() == 0) check("extra_beat", 1, 0);
          else begin
            e = exp_q.pop_front();
            check("beat_dat", frame_tdata, e.dat);
            check("beat_last", frame_tlast, e.last);
            if (e.last) begin
              idle_chk = 1;
              idle_exp = e.fin;
            end
          end
          beats++;
        end else if (beats > 0 && exp_q.size() > 0) gaps++;
        prev_stall = frame_tvalid && !frame_tready;
        held = frame_tdata;
      end else begin
        prev_stall = 0;
        idle_chk = 0;
      end
      @(posedge aclk);
      #1;
      if (hs1 && src1.size() > 0) void'(src1.pop_front());
      if (hs2 && src2.size() > 0) void'(src2.pop_front());
      if (f2_hold > 0) f2_hold--;
      func_1_tvalid = src1.size() > 0;
      func_1_tdata  = (src1.size() > 0) ? src1[0] : '0;
      func_2_tvalid = (src2.size() > 0) && (f2_hold == 0);
      func_2_tdata  = (src2.size() > 0) ? src2[0] : '0;
      frame_tready  = rdy_alt ? !frame_tready : 1'b1;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge aclk);
    #2;
  endtask

  // Sample values: func_1 = k+1+100f, func_2 = 10(k+1)+100f for frame f.
  task automatic load(input int n1, input int n2, input int nexp, input int nsrc);
    exp_t e;
    logic [31:0] a, b;
    for (int f = 0; f < nsrc; f++) begin
      for (int k = 0; k < n1; k++) src1.push_back(32'(k + 1 + f * 100));
      for (int k = 0; k < n2; k++) src2.push_back(32'(10 * (k + 1) + f * 100));
    end
    for (int f = 0; f < nexp; f++) begin
      for (int k = 0; k < NFFT; k++) begin
        a = (k < n1) ? 32'(k + 1 + f * 100) : 32'd0;
        b = (k < n2) ? 32'(10 * (k + 1) + f * 100) : 32'd0;
        e.dat  = {b, a};
        e.last = (k == NFFT - 1);
        e.fin  = (k == NFFT - 1) && (f == nexp - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic start_run(input int n1, input int n2, input int nf);
    tick();
    N1 = LW'(n1); N2 = LW'(n2); n_frames = 8'(nf);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic begin_test();
    beats = 0; gaps = 0; mon_en = 1;
  endtask

  task automatic wait_done(input int budget);
    int c = 0;
    while (!(idle && exp_q.size() == 0) && c < budget) begin
      @(negedge aclk);
      c++;
    end
    if (c >= budget) check("done_timeout", 0, 1);
    tick();
  endtask

  task automatic wait_beats(input int n);
    int c = 0;
    while (beats < n && c < 300) begin
      @(negedge aclk);
      c++;
    end
    if (c >= 300) check("beat_timeout", 0, 1);
  endtask

  initial begin
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check("rst_idle", idle, 1);
    check("rst_cfg_err", cfg_err, 0);
    check("rst_frames_done", frames_done, 0);
    check("rst_treadys", {func_1_tready, func_2_tready}, 0);
    check("rst_out", {frame_tvalid, frame_tlast, frame_tdata}, 0);
    tick();
    areset = 1'b0;

    // 1: basic frame
    begin_test();
    load(3, 2, 1, 1);
    start_run(3, 2, 1);
    @(negedge aclk);
    check("t1_idle_low", idle, 0);
    wait_done(100);
    check("t1_beats", beats, 8);
    check("t1_gaps", gaps, 0);
    check("t1_frames_done", frames_done, 1);

    // 2: config checking
    start_run(5, 5, 1);
    @(negedge aclk);
    check("t2_cfg_err", cfg_err, 1);
    check("t2_idle", idle, 1);
    check("t2_treadys", {func_1_tready, func_2_tready}, 0);
    @(negedge aclk);
    check("t2_cfg_err_drop", cfg_err, 0);
    check("t2_idle_stays", idle, 1);
    begin_test();
    load(5, 4, 1, 1);
    start_run(5, 4, 1);
    @(negedge aclk);
    check("t2_ok_idle_low", idle, 0);
    wait_done(100);
    check("t2_beats", beats, 8);
    start_run(0, 3, 1);
    @(negedge aclk);
    check("t2_n1_zero_err", cfg_err, 1);
    check("t2_n1_zero_idle", idle, 1);

    // 3: func_2 late, sink throttled
    begin_test();
    load(3, 2, 1, 1);
    f2_hold = 4;
    rdy_alt = 1;
    start_run(3, 2, 1);
    wait_done(200);
    rdy_alt = 0;
    check("t3_beats", beats, 8);
    check("t3_frames_done", frames_done, 1);

    // 4: continuous, abort in frame 2
    begin_test();
    load(3, 2, 2, 3);
    start_run(3, 2, 0);
    wait_beats(10);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    wait_done(200);
    check("t4_frames_done", frames_done, 2);
    repeat (20) @(negedge aclk);
    check("t4_no_third", frame_tvalid, 0);
    check("t4_idle", idle, 1);
    tick();
    src1.delete();
    src2.delete();

    // 5: reset mid-frame, then rerun case 1
    begin_test();
    load(3, 2, 1, 1);
    start_run(3, 2, 1);
    wait_beats(4);
    tick();
    mon_en = 0;
    areset = 1'b1;
    tick();
    @(negedge aclk);
    check("t5_idle", idle, 1);
    check("t5_cfg_err", cfg_err, 0);
    check("t5_frames_done", frames_done, 0);
    check("t5_treadys", {func_1_tready, func_2_tready}, 0);
    check("t5_out", {frame_tvalid, frame_tlast, frame_tdata}, 0);
    tick();
    areset = 1'b0;
    exp_q.delete();
    src1.delete();
    src2.delete();
    tick();
    begin_test();
    load(3, 2, 1, 1);
    start_run(3, 2, 1);
    wait_done(100);
    check("t5_beats", beats, 8);
    check("t5_gaps", gaps, 0);
    check("t5_frames_done_after", frames_done, 1);

    // 6: three back-to-back frames
    begin_test();
    load(1, 1, 3, 3);
    start_run(1, 1, 3);
    wait_done(200);
    check("t6_beats", beats, 24);
    check("t6_gaps", gaps, 0);
    check("t6_frames_done", frames_done, 3);
    check("t6_idle", idle, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/fft_corr_frame_builder.md
Name: fft_corr_frame_builder

Overview:
Input framing stage for the FFT correlation datapath, generalised in data width, frame length and frame count. Per start command it takes N1 samples of func_1 and N2 samples of func_2 from two AXI-Stream inputs. Each sequence is zero-padded to NFFT points. The two sequences are emitted as one lane-paired NFFT-beat frame, with tlast, to the forward FFT. It supports repeated frames per start (counted or continuous), a graceful abort, and configuration checking.

Parameters:
NFFT, 256, frame length in points; power of two, 8..8192
DATA_W, 32, width of one sample (packed complex as used by the FFT core)
LEN_W, 13, width of N1/N2 length inputs

Ports:
aclk  in  1  clock
areset  in  1  synchronous active-high reset
N1  in  LEN_W  func_1 sample count, sampled at accepted start
N2  in  LEN_W  func_2 sample count, sampled at accepted start
n_frames  in  8  frames per start; 0 = continuous until abort
start  in  1  start request, honoured only while idle
abort  in  1  stop after the current frame
idle  out  1  high when no frame sequence is active
cfg_err  out  1  one-cycle pulse on a rejected start
frames_done  out  8  frames completed since last accepted start (wraps)
func_1_tdata  in  DATA_W  sequence 1 data
func_1_tvalid  in  1  sequence 1 valid
func_1_tready  out  1  sequence 1 ready
func_2_tdata  in  DATA_W  sequence 2 data
func_2_tvalid  in  1  sequence 2 valid
func_2_tready  out  1  sequence 2 ready
frame_tdata  out  2*DATA_W  {func_2 sample, func_1 sample}
frame_tvalid  out  1  frame beat valid
frame_tlast  out  1  high on point NFFT-1
frame_tready  in  1  downstream ready

Behaviour:
- Reset values, applied the cycle after areset is high: idle=1, cfg_err=0, frames_done=0, all tready=0, frame_tvalid=0, frame_tlast=0, frame_tdata=0. State is IDLE. Reset mid-frame discards the partial frame and any latched abort.
- States are IDLE and RUN.
- In IDLE, start=1 latches N1, N2 and n_frames.
- Config is valid when N1>=1, N2>=1 and N1+N2-1<=NFFT, with the sum computed at LEN_W+1 bits.
  - Valid config: go to RUN next cycle, idle=0 next cycle, frames_done cleared, point index k=0.
  - Invalid config: cfg_err=1 for exactly one cycle, stay in IDLE, no tready asserted.
- Output register is one entry. adv = RUN && (!frame_tvalid || frame_tready).
- Point k needs input from sequence i when k<Ni.
- need1 = k<N1. need2 = k<N2.
- A beat is taken when adv && (!need1 || func_1_tvalid) && (!need2 || func_2_tvalid).
  - func_1_tready = adv && need1 && (!need2 || func_2_tvalid). func_2_tready is symmetric.
  - Both inputs handshake in the same cycle or neither does. There is no partial consumption.
- On a taken beat the register loads, the next cycle:
  - lane 1 = need1 ? func_1_tdata : 0
  - lane 2 = need2 ? func_2_tdata : 0
  - frame_tlast = (k==NFFT-1)
  - frame_tvalid = 1
  - k then increments.
- Latency from input handshake to frame_tvalid is 1 cycle.
- Once both counts are exhausted, padding beats issue at full rate whenever adv is true.
- If adv is true and no beat is taken, frame_tvalid drops. Output data holds stable while frame_tvalid && !frame_tready.
- At the frame_tlast handshake: frames_done increments and k returns to 0. The next frame needs fresh input samples (N1/N2 reused).
- The run ends at the last handshake when either:
  - frames_done reaches n_frames (n_frames != 0), or
  - abort was seen at any point during the frame (sticky flag).
  On ending, go to IDLE; idle=1 the cycle after that handshake.
- abort in IDLE is ignored. abort never truncates a frame.
- start while in RUN is ignored.
- A simultaneous start and abort in IDLE runs the start normally.
- frames_done wraps 255 to 0 in continuous mode.

Test Plan:
1. NFFT=8, N1=3, N2=2, n_frames=1, f1=1,2,3, f2=10,20, frame_tready=1 -> 8 beats {10,1},{20,2},{0,3},{0,0}x5; tlast only on beat 8; frames_done=1; idle=1 one cycle after last beat.
2. NFFT=8: N1=5, N2=5 -> cfg_err single-cycle pulse, idle stays 1, tready never asserted. N1=5, N2=4 -> accepted, 8 beats. N1=0 -> cfg_err.
3. Case 1 with func_2_tvalid delayed 3 cycles and frame_tready alternating 1/0 -> no func_1 handshake before func_2 valid; output sequence identical to case 1; data stable while stalled; no duplicated or dropped beat.
4. n_frames=0, abort pulsed during frame 2 -> frame 2 completes with tlast; idle=1 after it; frames_done=2; no third frame.
5. areset asserted at beat 4 of a frame -> all outputs at reset values next cycle. A new start with case 1 values reproduces case 1 exactly.
6. n_frames=3, N1=N2=1 at full throughput -> 24 contiguous beats, tlast on beats 8, 16 and 24, frames_done=3, then idle.
